uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_baud_gen.sv | 23 ++
 rtl/uart_tx.sv | 81 ++++++++
 tb/tb_uart_tx.sv | 119 +++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART FSM state type and default timing parameters
// Optional feature macro: UART_TX_PARITY_EN adds the PARITY state.
package uart_pkg;
    localparam int DEFAULT_CLKS_PER_BIT = 868;
    localparam int DEFAULT_DATA_BITS    = 8;
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } uart_state_t;
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period timer that pulses bit_done on the last cycle of each bit
// Ports: CLOCK_50 clock; reset sync active-high; clear holds the counter at 0;
//        bit_done high when the counter reaches CLKS_PER_BIT-1.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic clear,
    output logic bit_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    logic [CW-1:0] cnt;
    assign bit_done = cnt == CW'(CLKS_PER_BIT - 1);
    always_ff @(posedge CLOCK_50) begin
        if (reset || clear || bit_done)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, start + DATA_BITS LSB-first + optional even parity + stop
// Ports: CLOCK_50 clock; reset sync active-high; tx_data/tx_valid/tx_ready accept handshake;
//        tx registered serial line (idle high); busy high outside IDLE.
// Macro UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);
    localparam int IW = $clog2(DATA_BITS);
    uart_state_t state, state_n;
    logic [DATA_BITS-1:0] data_q, data_n;
    logic [IW-1:0] idx, idx_n;
    logic tx_n, bit_done;
    assign tx_ready = (state == IDLE) && !reset;
    assign busy     = state != IDLE;
    // Timer is held cleared in IDLE so the start bit gets a full period from the accept.
    uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .clear    (state == IDLE),
        .bit_done (bit_done)
    );
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state  <= IDLE;
            tx     <= 1'b1;
            data_q <= '0;
            idx    <= '0;
        end else begin
            state  <= state_n;
            tx     <= tx_n;
            data_q <= data_n;
            idx    <= idx_n;
        end
    end
    always_comb begin
        state_n = state;
        data_n  = data_q;
        idx_n   = idx;
        case (state)
            IDLE: if (tx_valid) begin
                state_n = START;
                data_n  = tx_data;
                idx_n   = '0;
            end
            START: if (bit_done) state_n = DATA;
            DATA: if (bit_done) begin
                if (idx == IW'(DATA_BITS - 1))
`ifdef UART_TX_PARITY_EN
                    state_n = PARITY;
`else
                    state_n = STOP;
`endif
                else
                    idx_n = idx + IW'(1);
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_done) state_n = STOP;
`endif
            STOP: if (bit_done) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // tx is computed from the next state so the line is a pure register output.
        tx_n = (state_n == START) ? 1'b0 :
               (state_n == DATA)  ? data_n[idx_n] :
`ifdef UART_TX_PARITY_EN
               (state_n == PARITY) ? ^data_q :
`endif
               1'b1;
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx with CLKS_PER_BIT=4, DATA_BITS=8
module tb_uart_tx;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    logic CLOCK_50 = 1'b0;
    logic reset, tx_valid, tx_ready, tx, busy;
    logic [7:0] tx_data;
    int n_cmp = 0;
    int n_err = 0;

    uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx       (tx),
        .busy     (busy)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge where the accept is set up; checks every cycle of the frame
    // against the hand-expanded bit pattern, then the single IDLE cycle that follows.
    task automatic frame(input string tag, input logic [7:0] b, input int chg_at,
                         input logic [7:0] chg_data, input logic keep_valid);
        logic [7:0] rx;
        logic exp_bit;
        int k;
        rx = '0;
        for (int i = 1; i <= NBITS * CPB; i++) begin
            @(negedge CLOCK_50);
            if (i == 1) tx_valid = keep_valid;
            if (i == chg_at) tx_data = chg_data;
            k = (i - 1) / CPB;
            exp_bit = (k == 0) ? 1'b0 : (k <= 8) ? b[k-1] : (k == 9 && NBITS == 11) ? ^b : 1'b1;
            chk($sformatf("%s tx cyc%0d", tag, i), {7'd0, tx}, {7'd0, exp_bit});
            if ((i - 1) % CPB == 1 && k >= 1 && k <= 8) rx[k-1] = tx;
            if (i % 8 == 3) chk($sformatf("%s busy cyc%0d", tag, i), {7'd0, busy}, 8'd1);
            if (i % 8 == 3) chk($sformatf("%s ready cyc%0d", tag, i), {7'd0, tx_ready}, 8'd0);
        end
        chk({tag, " decoded"}, rx, b);
        @(negedge CLOCK_50);
        chk({tag, " idle tx"}, {7'd0, tx}, 8'd1);
        chk({tag, " idle ready"}, {7'd0, tx_ready}, 8'd1);
        chk({tag, " idle busy"}, {7'd0, busy}, 8'd0);
    endtask

    initial begin
        reset = 1'b1;
        tx_valid = 1'b0;
        tx_data = 8'h00;
        repeat (3) @(negedge CLOCK_50);
        chk("rst tx", {7'd0, tx}, 8'd1);
        chk("rst busy", {7'd0, busy}, 8'd0);
        chk("rst ready", {7'd0, tx_ready}, 8'd0);
        reset = 1'b0;
        @(negedge CLOCK_50);
        chk("post-rst ready", {7'd0, tx_ready}, 8'd1);
        chk("post-rst tx", {7'd0, tx}, 8'd1);
        chk("post-rst busy", {7'd0, busy}, 8'd0);
        repeat (2) @(negedge CLOCK_50);
        chk("idle tx", {7'd0, tx}, 8'd1);

        tx_data = 8'h55;
        tx_valid = 1'b1;
        frame("f55", 8'h55, 0, 8'h00, 1'b0);

        tx_data = 8'hA5;
        tx_valid = 1'b1;
        frame("fA5", 8'hA5, 10, 8'h3C, 1'b1);
        frame("f3C", 8'h3C, 0, 8'h00, 1'b0);

        tx_data = 8'h00;
        tx_valid = 1'b1;
        frame("f00", 8'h00, 15, 8'hFF, 1'b0);

        tx_data = 8'h96;
        tx_valid = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            @(negedge CLOCK_50);
            if (i == 1) tx_valid = 1'b0;
        end
        chk("pre-abort tx bit3", {7'd0, tx}, 8'd0);
        reset = 1'b1;
        @(negedge CLOCK_50);
        chk("abort tx", {7'd0, tx}, 8'd1);
        chk("abort busy", {7'd0, busy}, 8'd0);
        chk("abort ready", {7'd0, tx_ready}, 8'd0);
        reset = 1'b0;
        for (int i = 0; i < 3 * CPB; i++) begin
            @(negedge CLOCK_50);
            chk($sformatf("after abort tx %0d", i), {7'd0, tx}, 8'd1);
            chk($sformatf("after abort busy %0d", i), {7'd0, busy}, 8'd0);
        end
        tx_data = 8'hC3;
        tx_valid = 1'b1;
        frame("fC3", 8'hC3, 0, 8'h00, 1'b0);

        tx_data = 8'h07;
        tx_valid = 1'b1;
        frame("f07", 8'h07, 0, 8'h00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
